dds_sweep_ctrl: RTL
===================

// Module: dds_sweep_ctrl
// PURPOSE
//   Frequency-sweep sequencer for one DDS channel of the FunctionGenerator.
//   Latches a sweep config on start, then steps the channel's frequency tuning word (FTW).
//   Steps run from ftw_start to ftw_stop, holding each value for a programmable dwell.
//   One instance per channel (dds_ch1/dds_ch2); ftw_o feeds the DDS phase accumulator increment.
// PARAMETERS
//   FTW_W    32  width of tuning word / phase increment
//   DWELL_W  24  width of dwell counter (cycles per step)
// PORTS
//   sys_clk_i     in   1        system clock (100 MHz)
//   sys_rst_i     in   1        async reset, active-high
//   start_i       in   1        start sweep; sampled only in IDLE
//   abort_i       in   1        abort sweep; any state
//   mode_i        in   2        00 single, 01 repeat (sawtooth), 10 triangle, 11 = single
//   ftw_start_i   in   FTW_W    first FTW
//   ftw_stop_i    in   FTW_W    end FTW
//   ftw_step_i    in   FTW_W    unsigned step magnitude
//   dwell_i       in   DWELL_W  cycles each FTW is held; 0 treated as 1
//   ftw_o         out  FTW_W    current tuning word (registered)
//   ftw_valid_o   out  1        1-cycle pulse whenever ftw_o takes a new value
//   busy_o        out  1        sweep active
//   done_o        out  1        1-cycle pulse at natural end of single sweep
//   dir_o         out  1        current direction: 0 = rising FTW, 1 = falling
// BEHAVIOUR
// - Reset (async, immediate): ftw_o=0, ftw_valid_o=0, busy_o=0, done_o=0, dir_o=0, state IDLE.
// - FSM states:
//     IDLE:  start_i & !abort_i -> RUN; latch all config inputs.
//            Cycle after start: ftw_o=ftw_start, ftw_valid_o=1, busy_o=1.
//            Direction is set at latch: dir_o = (ftw_start > ftw_stop).
//     RUN:   each FTW is held exactly dwell cycles, counting the valid-pulse cycle.
//            Then next = cur +/- step per dir_o.
//            If next reaches/passes the endpoint, or the add/sub overflows FTW_W, next = endpoint exactly.
//            No wrap-around, ever.
//     END:   endpoint has been held for dwell cycles:
//            single   -> IDLE; done_o=1 and busy_o=0 in the same cycle; ftw_o holds endpoint.
//            repeat   -> ftw_o=ftw_start (valid pulse) next cycle; continue.
//            triangle -> toggle dir_o; swap endpoint role (stop<->start); continue stepping.
//                        The endpoint value is not emitted twice.
// - ftw_start == ftw_stop, or step == 0:
//     - emit ftw_start once and hold for dwell cycles;
//     - then single ends (done);
//     - repeat/triangle re-emit ftw_start each dwell period.
// - abort_i: next cycle state IDLE, busy_o=0; no done_o; ftw_o holds last value.
//   abort_i beats start_i when both are high in IDLE.
// - start_i while busy: ignored; config changes while busy: ignored until the next start.
// - Config inputs are used only through the latched copies (safe to change mid-sweep).
// - Latency start->first ftw_valid_o: 1 cycle. Step-to-step spacing: dwell cycles.
// TESTING
// 1. single, start=100 stop=130 step=10 dwell=4, start at cycle 0:
//    ftw 100@1-4, 110@5-8, 120@9-12, 130@13-16; done_o@17; valid pulses at 1,5,9,13.
// 2. overshoot, start=0 stop=25 step=10 dwell=1 -> 0,10,20,25 consecutive cycles; done_o after 25.
// 3. down sweep, start=50 stop=20 step=15 dwell=1 -> 50,35,20; dir_o=1 throughout; done_o next cycle.
// 4. triangle, start=0 stop=20 step=10 dwell=2 -> 0,10,20,10,0,10,... each held 2 cycles, dir_o toggles at 20/0.
//    abort_i -> busy_o=0 next cycle, ftw_o frozen, no done_o.
// 5. overflow guard, start=0xFFFFFFF0 stop=0xFFFFFFFF step=0x20 -> 0xFFFFFFF0 then 0xFFFFFFFF; never 0x10.
// 6. sys_rst_i asserted mid-sweep between clock edges -> all outputs 0 immediately.
//    After release, start_i re-runs case 1 identically.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for one DDS channel: steps the tuning word from a
// latched start value to a latched stop value, holding each word for a dwell period.
module dds_sweep_ctrl #(
  parameter int unsigned FTW_W   = 32,
  parameter int unsigned DWELL_W = 24
) (
  input  logic               sys_clk_i,
  input  logic               sys_rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [1:0]         mode_i,
  input  logic [FTW_W-1:0]   ftw_start_i,
  input  logic [FTW_W-1:0]   ftw_stop_i,
  input  logic [FTW_W-1:0]   ftw_step_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [FTW_W-1:0]   ftw_o,
  output logic               ftw_valid_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               dir_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_END
  } state_t;

  typedef enum logic [1:0] {
    MODE_SINGLE     = 2'b00,
    MODE_REPEAT     = 2'b01,
    MODE_TRIANGLE   = 2'b10,
    MODE_SINGLE_ALT = 2'b11
  } sweep_mode_t;

  state_t             state_q, state_d;
  logic [FTW_W-1:0]   ftw_q, ftw_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dir_q, dir_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  // Latched sweep configuration
  sweep_mode_t        mode_q;
  logic [FTW_W-1:0]   start_q, lo_q, hi_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               dir0_q, deg_q;

  logic               load;
  logic               deg_in;
  logic               hold_done;
  logic [FTW_W-1:0]   target;
  logic [FTW_W:0]     up_sum, dn_diff;
  logic [FTW_W-1:0]   up_next, dn_next;

  assign load   = (state_q == ST_IDLE) && start_i && !abort_i;
  assign deg_in = (ftw_start_i == ftw_stop_i) || (ftw_step_i == '0);

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      mode_q  <= MODE_SINGLE;
      start_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      step_q  <= '0;
      dwell_q <= DWELL_W'(1);
      dir0_q  <= 1'b0;
      deg_q   <= 1'b0;
    end else if (load) begin
      mode_q  <= sweep_mode_t'(mode_i);
      start_q <= ftw_start_i;
      lo_q    <= (ftw_start_i > ftw_stop_i) ? ftw_stop_i : ftw_start_i;
      hi_q    <= (ftw_start_i > ftw_stop_i) ? ftw_start_i : ftw_stop_i;
      step_q  <= ftw_step_i;
      dwell_q <= (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
      dir0_q  <= ftw_start_i > ftw_stop_i;
      deg_q   <= deg_in;
    end
  end

  // Rising steps saturate at hi, falling steps at lo; a carry or borrow out of
  // FTW_W bits also clamps, so the word can never wrap.
  assign up_sum    = {1'b0, ftw_q} + {1'b0, step_q};
  assign dn_diff   = {1'b0, ftw_q} - {1'b0, step_q};
  assign up_next   = (up_sum[FTW_W] || (up_sum[FTW_W-1:0] >= hi_q)) ? hi_q : up_sum[FTW_W-1:0];
  assign dn_next   = (dn_diff[FTW_W] || (dn_diff[FTW_W-1:0] <= lo_q)) ? lo_q : dn_diff[FTW_W-1:0];
  assign target    = dir_q ? lo_q : hi_q;
  assign hold_done = (cnt_q == dwell_q);

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
      ftw_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ftw_q   <= ftw_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // ST_RUN holds intermediate words, ST_END holds the current endpoint (or the
  // single word of a degenerate sweep).
  always_comb begin
    state_d = state_q;
    ftw_d   = ftw_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    cnt_d   = cnt_q;

    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load) begin
            state_d = deg_in ? ST_END : ST_RUN;
            ftw_d   = ftw_start_i;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            dir_d   = ftw_start_i > ftw_stop_i;
            cnt_d   = DWELL_W'(1);
          end
        end

        ST_RUN: begin
          if (!hold_done) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            ftw_d   = dir_q ? dn_next : up_next;
            valid_d = 1'b1;
            cnt_d   = DWELL_W'(1);
            state_d = ((dir_q ? dn_next : up_next) == target) ? ST_END : ST_RUN;
          end
        end

        ST_END: begin
          if (!hold_done) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            unique case (mode_q)
              MODE_REPEAT: begin
                ftw_d   = start_q;
                valid_d = 1'b1;
                cnt_d   = DWELL_W'(1);
                dir_d   = dir0_q;
                state_d = deg_q ? ST_END : ST_RUN;
              end
              MODE_TRIANGLE: begin
                valid_d = 1'b1;
                cnt_d   = DWELL_W'(1);
                if (deg_q) begin
                  ftw_d = start_q;
                end else begin
                  // Turn around: the endpoint already shown is skipped and the
                  // first word emitted is one step back toward the other end.
                  dir_d   = !dir_q;
                  ftw_d   = dir_q ? up_next : dn_next;
                  state_d = ((dir_q ? up_next : dn_next) == (dir_q ? hi_q : lo_q)) ? ST_END : ST_RUN;
                end
              end
              default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            endcase
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign ftw_o       = ftw_q;
  assign ftw_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign dir_o       = dir_q;

endmodule
